// File: rtl/mult_pkg.sv
// Shared types and default sizing for the multiplier arbiter.
// The tag id width comes from NUM_REQ here, so instances must not exceed it.
package mult_pkg;

  localparam int DATA_LEN     = 32;
  localparam int NUM_REQ      = 4;
  localparam int MULT_LATENCY = 3;
  localparam int ID_W         = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef logic [ID_W-1:0] req_id_t;

  typedef struct packed {
    logic    vld;
    req_id_t id;
  } mult_tag_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin grant over NUM_REQ requesters; the search starts at ptr and wraps.
// The pointer moves to one past the winner on every grant and holds otherwise.
module rr_arbiter
  import mult_pkg::*;
#(
  parameter int NUM_REQ = mult_pkg::NUM_REQ
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_REQ-1:0] req,
  output logic [NUM_REQ-1:0] grant,
  output req_id_t            grant_id,
  output logic               grant_any
);

  req_id_t ptr;

  // Grant is forced low while reset is held, so ready reads zero during reset.
  always_comb begin
    int idx;
    idx       = 0;
    grant     = '0;
    grant_id  = '0;
    grant_any = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = (int'(ptr) + k) % NUM_REQ;
      if (!grant_any && req[idx]) begin
        grant[idx] = 1'b1;
        grant_id   = req_id_t'(idx);
        grant_any  = 1'b1;
      end
    end
    if (!reset) begin
      grant     = '0;
      grant_id  = '0;
      grant_any = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ptr <= '0;
    end else if (grant_any) begin
      ptr <= (grant_id == req_id_t'(NUM_REQ - 1)) ? '0 : grant_id + 1'b1;
    end
  end

endmodule

// File: rtl/mult_arbiter.sv
// Shares one pipelined multiplier among NUM_REQ requesters and routes each
// product back to its requester using a tag pipeline that tracks every issue.
module mult_arbiter
  import mult_pkg::*;
#(
  parameter int DATA_LEN     = mult_pkg::DATA_LEN,
  parameter int NUM_REQ      = mult_pkg::NUM_REQ,
  parameter int MULT_LATENCY = mult_pkg::MULT_LATENCY
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [NUM_REQ-1:0]          req_valid,
  output logic [NUM_REQ-1:0]          req_ready,
  input  logic [NUM_REQ*DATA_LEN-1:0] req_a,
  input  logic [NUM_REQ*DATA_LEN-1:0] req_b,
  output logic [DATA_LEN-1:0]         mul_a,
  output logic [DATA_LEN-1:0]         mul_b,
  input  logic [DATA_LEN-1:0]         mul_result,
  output logic [NUM_REQ-1:0]          resp_valid,
  output logic [DATA_LEN-1:0]         resp_data,
  output logic                        idle
);

  logic      grant_any;
  req_id_t   grant_id;
  mult_tag_t issue_tag;
  mult_tag_t tag_pipe [MULT_LATENCY];
  mult_tag_t exit_tag;
  logic      any_tag;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .clk       (clk),
    .reset     (reset),
    .req       (req_valid),
    .grant     (req_ready),
    .grant_id  (grant_id),
    .grant_any (grant_any)
  );

  // issue_tag rides alongside the operand register; the multiplier's own
  // MULT_LATENCY stages are then mirrored by tag_pipe.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mul_a     <= '0;
      mul_b     <= '0;
      issue_tag <= '0;
    end else begin
      issue_tag <= '{vld: grant_any, id: grant_id};
      if (grant_any) begin
        mul_a <= req_a[int'(grant_id)*DATA_LEN +: DATA_LEN];
        mul_b <= req_b[int'(grant_id)*DATA_LEN +: DATA_LEN];
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < MULT_LATENCY; i++) tag_pipe[i] <= '0;
    end else begin
      tag_pipe[0] <= issue_tag;
      for (int i = 1; i < MULT_LATENCY; i++) tag_pipe[i] <= tag_pipe[i-1];
    end
  end

  assign exit_tag = tag_pipe[MULT_LATENCY-1];

  // Slots issued without a transfer carry vld=0, so their stale products are dropped here.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      resp_valid <= '0;
      resp_data  <= '0;
    end else begin
      resp_valid <= exit_tag.vld ? (NUM_REQ'(1) << exit_tag.id) : '0;
      if (exit_tag.vld) resp_data <= mul_result;
    end
  end

  always_comb begin
    any_tag = issue_tag.vld;
    for (int i = 0; i < MULT_LATENCY; i++) any_tag = any_tag | tag_pipe[i].vld;
  end

  assign idle = ~any_tag & ~grant_any;

endmodule

// File: tb/tb_mult_arbiter.sv
// Directed + randomized bench for mult_arbiter with a 3-stage multiplier model and
// a queue-based reference of round-robin order and per-op response timing.
module tb_mult_arbiter;

  localparam int N  = 4;
  localparam int W  = 32;
  localparam int RESP_DELAY = 4;

  logic             clk = 1'b0;
  logic             reset;
  logic [N-1:0]     req_valid;
  logic [N-1:0]     req_ready;
  logic [N*W-1:0]   req_a;
  logic [N*W-1:0]   req_b;
  logic [W-1:0]     mul_a;
  logic [W-1:0]     mul_b;
  logic [W-1:0]     mul_result;
  logic [N-1:0]     resp_valid;
  logic [W-1:0]     resp_data;
  logic             idle;

  mult_arbiter dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_a      (req_a),
    .req_b      (req_b),
    .mul_a      (mul_a),
    .mul_b      (mul_b),
    .mul_result (mul_result),
    .resp_valid (resp_valid),
    .resp_data  (resp_data),
    .idle       (idle)
  );

  always #5 clk = ~clk;

  // Stand-in multiplier: three registers between operands and product.
  logic [W-1:0] mpipe [3];
  always @(posedge clk) begin
    mpipe[0] <= mul_a * mul_b;
    mpipe[1] <= mpipe[0];
    mpipe[2] <= mpipe[1];
  end
  assign mul_result = mpipe[2];

  typedef struct {
    int           id;
    logic [W-1:0] prod;
    int           due;
  } exp_t;

  exp_t         exp_q [$];
  logic [W-1:0] exp_data;
  int           m_ptr;
  int           cyc;
  int           compared;
  int           mismatched;

  logic         pend [N];
  logic [W-1:0] pa [N];
  logic [W-1:0] pb [N];

  logic [N-1:0] ready_log [$];
  logic [N-1:0] resp_v [$];
  logic [W-1:0] resp_d [$];
  int           resp_c [$];

  task automatic checkOutput(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed=0x%08h expected=0x%08h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic clearLogs();
    ready_log.delete();
    resp_v.delete();
    resp_d.delete();
    resp_c.delete();
  endtask

  // One clock: drive at negedge, check grant/idle, then check issue and responses after the edge.
  task automatic applyStimulus();
    int           gid;
    logic [N-1:0] exp_v;
    logic [W-1:0] acc_a;
    logic [W-1:0] acc_b;
    for (int i = 0; i < N; i++) begin
      req_valid[i]     = pend[i];
      req_a[i*W +: W]  = pa[i];
      req_b[i*W +: W]  = pb[i];
    end
    #1;
    gid = -1;
    for (int k = 0; k < N; k++) begin
      if (gid < 0 && pend[(m_ptr + k) % N]) gid = (m_ptr + k) % N;
    end
    checkOutput("req_ready", W'(req_ready), (gid >= 0) ? (W'(1) << gid) : '0);
    checkOutput("idle", W'(idle), W'(exp_q.size() == 0 && gid < 0));
    ready_log.push_back(req_ready);
    acc_a = (gid >= 0) ? pa[gid] : '0;
    acc_b = (gid >= 0) ? pb[gid] : '0;
    @(posedge clk);
    cyc++;
    if (gid >= 0) begin
      exp_q.push_back('{id: gid, prod: acc_a * acc_b, due: cyc + RESP_DELAY});
      m_ptr     = (gid + 1) % N;
      pend[gid] = 1'b0;
    end
    #1;
    if (gid >= 0) begin
      checkOutput("mul_a", mul_a, acc_a);
      checkOutput("mul_b", mul_b, acc_b);
    end
    exp_v = '0;
    if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
      exp_v    = N'(1) << exp_q[0].id;
      exp_data = exp_q[0].prod;
      void'(exp_q.pop_front());
    end
    checkOutput("resp_valid", W'(resp_valid), W'(exp_v));
    checkOutput("resp_data", resp_data, exp_data);
    if (resp_valid != '0) begin
      resp_v.push_back(resp_valid);
      resp_d.push_back(resp_data);
      resp_c.push_back(cyc);
    end
    @(negedge clk);
  endtask

  task automatic drain(input int n);
    for (int k = 0; k < n; k++) applyStimulus();
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int cyc0;
    compared   = 0;
    mismatched = 0;
    cyc        = 0;
    m_ptr      = 0;
    exp_data   = '0;
    for (int i = 0; i < N; i++) begin
      pend[i] = 1'b0;
      pa[i]   = '0;
      pb[i]   = '0;
    end
    reset     = 1'b0;
    req_valid = '0;
    req_a     = '0;
    req_b     = '0;

    // Reset held with random requests: everything must sit at reset values.
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      req_valid = N'($urandom);
      req_a     = {$urandom, $urandom, $urandom, $urandom};
      req_b     = {$urandom, $urandom, $urandom, $urandom};
      #1;
      checkOutput("rst_req_ready", W'(req_ready), '0);
      checkOutput("rst_mul_a", mul_a, '0);
      checkOutput("rst_mul_b", mul_b, '0);
      checkOutput("rst_resp_valid", W'(resp_valid), '0);
      checkOutput("rst_resp_data", resp_data, '0);
      checkOutput("rst_idle", W'(idle), 32'd1);
    end
    @(negedge clk);
    req_valid = '0;
    reset     = 1'b1;
    @(negedge clk);

    // Fairness: all four requesters continuously valid.
    clearLogs();
    for (int k = 0; k < 8; k++) begin
      for (int i = 0; i < N; i++) begin
        pend[i] = 1'b1;
        pa[i]   = W'(i + 1);
        pb[i]   = 32'd10;
      end
      applyStimulus();
    end
    for (int i = 0; i < N; i++) pend[i] = 1'b0;
    drain(6);
    for (int k = 0; k < 8; k++)
      checkOutput("fair_order", W'(ready_log[k]), W'(1) << (k % 4));
    checkOutput("fair_count", W'(resp_d.size()), 32'd8);
    for (int k = 0; k < 8 && k < resp_d.size(); k++)
      checkOutput("fair_product", resp_d[k], W'(10 * (k % 4 + 1)));

    // Single op from requester 0.
    clearLogs();
    cyc0 = cyc;
    pend[0] = 1'b1;
    pa[0]   = 32'd7;
    pb[0]   = 32'hFFFF_FFFD;
    applyStimulus();
    drain(6);
    checkOutput("single_count", W'(resp_v.size()), 32'd1);
    if (resp_v.size() > 0) begin
      checkOutput("single_valid", W'(resp_v[0]), 32'd1);
      checkOutput("single_data", resp_d[0], 32'hFFFF_FFEB);
      checkOutput("single_latency", W'(resp_c[0] - (cyc0 + 1)), 32'd4);
    end

    // Wrap and overflow on requester 3, then search restarts at 0.
    clearLogs();
    pend[3] = 1'b1;
    pa[3]   = 32'h7FFF_FFFF;
    pb[3]   = 32'd2;
    applyStimulus();
    drain(6);
    checkOutput("wrap_count", W'(resp_v.size()), 32'd1);
    if (resp_v.size() > 0) begin
      checkOutput("wrap_valid", W'(resp_v[0]), 32'h8);
      checkOutput("wrap_data", resp_d[0], 32'hFFFF_FFFE);
    end
    clearLogs();
    pend[1] = 1'b1;
    pa[1]   = 32'd5;
    pb[1]   = 32'd6;
    pend[3] = 1'b1;
    pa[3]   = 32'd9;
    pb[3]   = 32'hFFFF_FFFF;
    applyStimulus();
    checkOutput("wrap_next_grant", W'(ready_log[0]), 32'h2);
    drain(7);

    // Gaps: requester 1 valid only on relative cycles 0, 2 and 5.
    clearLogs();
    cyc0 = cyc;
    for (int c = 0; c < 14; c++) begin
      pend[1] = (c == 0 || c == 2 || c == 5);
      pa[1]   = $urandom;
      pb[1]   = $urandom;
      applyStimulus();
    end
    checkOutput("gap_count", W'(resp_v.size()), 32'd3);
    if (resp_c.size() == 3) begin
      checkOutput("gap_pulse0", W'(resp_c[0] - (cyc0 + 1)), 32'd4);
      checkOutput("gap_pulse1", W'(resp_c[1] - (cyc0 + 1)), 32'd6);
      checkOutput("gap_pulse2", W'(resp_c[2] - (cyc0 + 1)), 32'd9);
    end

    // Random traffic: requesters hold operands until accepted.
    for (int k = 0; k < 200; k++) begin
      for (int i = 0; i < N; i++) begin
        if (!pend[i] && $urandom_range(0, 2) != 0) begin
          pend[i] = 1'b1;
          pa[i]   = $urandom;
          pb[i]   = $urandom;
        end
      end
      applyStimulus();
    end
    for (int i = 0; i < N; i++) pend[i] = 1'b0;
    drain(6);

    // Reset mid-flight: three ops issued, reset one cycle later.
    for (int i = 0; i < 3; i++) begin
      pend[i] = 1'b1;
      pa[i]   = $urandom;
      pb[i]   = $urandom;
    end
    drain(4);
    reset = 1'b0;
    exp_q.delete();
    exp_data = '0;
    m_ptr    = 0;
    #1;
    checkOutput("mid_rst_resp_valid", W'(resp_valid), '0);
    checkOutput("mid_rst_resp_data", resp_data, '0);
    checkOutput("mid_rst_mul_a", mul_a, '0);
    checkOutput("mid_rst_idle", W'(idle), 32'd1);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    clearLogs();
    drain(8);
    checkOutput("post_rst_pulses", W'(resp_v.size()), '0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
